// File: rtl/serial_instr_rx.sv
// serial_instr_rx
//   Bit-serial instruction receiver.  INSTR_W bits arrive MSB first over a
//   4-phase data_ready/data_ack handshake.  The assembled word is then offered
//   on a valid/ready interface.  Also provides input synchronisers,
//   backpressure through the handshake, a mid-frame stall timeout with frame
//   abort, and debug outputs.
//
//   Optional build macro: SERIAL_INSTR_PARITY_EN.  When it is defined, each
//   frame carries one extra even-parity bit after the data bits.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   data_ready   sender strobe: data_bit valid (asynchronous to clk)
//   data_bit     serial data, MSB first
//   data_ack     bit captured (held until data_ready drops)
//   instruction  assembled word, stable while instr_valid=1
//   instr_valid  word available
//   instr_ready  consumer accepts the word
//   frame_err    1-cycle pulse on stall-timeout abort
//   parity_err   1-cycle pulse on parity failure (0 without parity build)
//   state        debug: 0=WAIT 1=ACK 2=DONE
//   bit_count    debug: bits captured in the current frame
module serial_instr_rx #(
   parameter  int unsigned INSTR_W     = 10,
   parameter  int unsigned SYNC_STAGES = 2,
   parameter  int unsigned TIMEOUT_CYC = 64,
   localparam int unsigned CNT_W       = $clog2(INSTR_W + 2)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               data_ready,
   input  logic               data_bit,
   output logic               data_ack,
   output logic [INSTR_W-1:0] instruction,
   output logic               instr_valid,
   input  logic               instr_ready,
   output logic               frame_err,
   output logic               parity_err,
   output logic [1:0]         state,
   output logic [CNT_W-1:0]   bit_count
);

`ifdef SERIAL_INSTR_PARITY_EN
   localparam int unsigned TOTAL = INSTR_W + 1;
`else
   localparam int unsigned TOTAL = INSTR_W;
`endif
   localparam int unsigned TMR_W    = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam int unsigned TMR_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;

   typedef enum logic [1:0] {
      ST_WAIT = 2'd0,
      ST_ACK  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   state_e               state_q, state_d;
   logic [SYNC_STAGES-1:0] rdy_sync_q, bit_sync_q;
   logic                 rdy_s, bit_s;
   logic [INSTR_W-1:0]   instr_q, instr_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [TMR_W-1:0]     timer_q, timer_d;
   logic                 ack_q, ack_d;
   logic                 valid_q, valid_d;
   logic                 ferr_q, ferr_d;
   logic                 perr_q, perr_d;
   logic                 timeout_hit_c;
   logic                 par_bad_c;
   logic                 frame_full_c;

   // Identical synchroniser chains keep data_bit aligned with data_ready
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdy_sync_q <= '0;
         bit_sync_q <= '0;
      end else begin
         rdy_sync_q <= {rdy_sync_q[SYNC_STAGES-2:0], data_ready};
         bit_sync_q <= {bit_sync_q[SYNC_STAGES-2:0], data_bit};
      end
   end

   assign rdy_s = rdy_sync_q[SYNC_STAGES-1];
   assign bit_s = bit_sync_q[SYNC_STAGES-1];

`ifdef SERIAL_INSTR_PARITY_EN
   // Running XOR over every bit of the frame, parity bit included
   logic par_q, par_d;
   assign par_bad_c = par_q;
`else
   assign par_bad_c = 1'b0;
`endif

   assign frame_full_c = (cnt_q == CNT_W'(TOTAL));

   // Stall timer expiry; only meaningful while a frame is in progress
   always_comb begin
      timeout_hit_c = 1'b0;
      if (TIMEOUT_CYC > 0) begin
         if ((state_q == ST_ACK) || ((state_q == ST_WAIT) && (cnt_q != '0))) begin
            timeout_hit_c = (timer_q == TMR_W'(TMR_LAST));
         end
      end
   end

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_WAIT;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; real handshake transitions win over a timeout
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_WAIT: begin
            if (rdy_s) begin
               state_d = ST_ACK;
            end
         end
         ST_ACK: begin
            if (!rdy_s) begin
               if (frame_full_c && !par_bad_c) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_WAIT;
               end
            end else if (timeout_hit_c) begin
               state_d = ST_WAIT;
            end
         end
         ST_DONE: begin
            if (instr_ready) begin
               state_d = ST_WAIT;
            end
         end
         default: state_d = ST_WAIT;
      endcase
   end

   // Output / datapath next values (all registered)
   always_comb begin
      instr_d = instr_q;
      cnt_d   = cnt_q;
      timer_d = '0;
      ack_d   = 1'b0;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      perr_d  = 1'b0;
`ifdef SERIAL_INSTR_PARITY_EN
      par_d   = par_q;
`endif
      case (state_q)
         ST_WAIT: begin
            if (rdy_s) begin
               ack_d = 1'b1;
               cnt_d = cnt_q + CNT_W'(1);
`ifdef SERIAL_INSTR_PARITY_EN
               // Trailing parity bit is checked, not stored
               if (cnt_q < CNT_W'(INSTR_W)) begin
                  instr_d = {instr_q[INSTR_W-2:0], bit_s};
               end
               par_d = ((cnt_q == '0) ? 1'b0 : par_q) ^ bit_s;
`else
               instr_d = {instr_q[INSTR_W-2:0], bit_s};
`endif
            end else if (cnt_q != '0) begin
               if (timeout_hit_c) begin
                  ferr_d  = 1'b1;
                  cnt_d   = '0;
                  instr_d = '0;
               end else if (TIMEOUT_CYC > 0) begin
                  timer_d = timer_q + TMR_W'(1);
               end
            end
         end
         ST_ACK: begin
            if (!rdy_s) begin
               if (frame_full_c) begin
                  if (par_bad_c) begin
                     perr_d  = 1'b1;
                     cnt_d   = '0;
                     instr_d = '0;
                  end else begin
                     valid_d = 1'b1;
                  end
               end
            end else if (timeout_hit_c) begin
               ferr_d  = 1'b1;
               cnt_d   = '0;
               instr_d = '0;
            end else begin
               ack_d = 1'b1;
               if (TIMEOUT_CYC > 0) begin
                  timer_d = timer_q + TMR_W'(1);
               end
            end
         end
         ST_DONE: begin
            if (instr_ready) begin
               cnt_d = '0;
            end else begin
               valid_d = 1'b1;
            end
         end
         default: begin
            cnt_d = '0;
         end
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         instr_q <= '0;
         cnt_q   <= '0;
         timer_q <= '0;
         ack_q   <= 1'b0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         perr_q  <= 1'b0;
`ifdef SERIAL_INSTR_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         instr_q <= instr_d;
         cnt_q   <= cnt_d;
         timer_q <= timer_d;
         ack_q   <= ack_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
         perr_q  <= perr_d;
`ifdef SERIAL_INSTR_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   assign data_ack    = ack_q;
   assign instruction = instr_q;
   assign instr_valid = valid_q;
   assign frame_err   = ferr_q;
   assign parity_err  = perr_q;
   assign state       = state_q;
   assign bit_count   = cnt_q;

endmodule

// File: doc/serial_instr_rx.md
Name: serial_instr_rx

Overview:
- Parametrised bit-serial instruction receiver for MBED-to-FPGA servo command transfer.
- Shifts in INSTR_W bits using a 4-phase data_ready/data_ack handshake, then presents the word to downstream logic on a valid/ready interface.
- Adds input synchronisers, backpressure, a stall timeout with frame abort, and debug observability.

Parameters:
INSTR_W, 10, instruction word width in bits (>=2)
SYNC_STAGES, 2, synchroniser flops on data_ready and data_bit (>=2)
TIMEOUT_CYC, 64, mid-frame stall limit in clk cycles; 0 disables the timeout

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
data_ready  in  1  from MBED: data_bit is valid (asynchronous to clk)
data_bit  in  1  serial data, MSB first; sender holds it stable while data_ready=1
data_ack  out  1  to MBED: current bit captured
instruction  out  INSTR_W  assembled word; stable while instr_valid=1
instr_valid  out  1  instruction available
instr_ready  in  1  consumer accepts; transfer occurs when instr_valid&&instr_ready at a clk edge
frame_err  out  1  1-cycle pulse on timeout abort
parity_err  out  1  1-cycle pulse on parity failure (see Optional Feature)
state  out  2  debug: 0=WAIT, 1=ACK, 2=DONE, 3=unused
bit_count  out  $clog2(INSTR_W+2)  debug: bits captured in the current frame

Behaviour:
- Reset (reset=0, asynchronous): every output is 0, state=WAIT, the shift register and timer are 0, and all synchroniser flops are 0. Deassertion is used as-is; a synchronous release is provided at system level.
- data_ready and data_bit pass through identical SYNC_STAGES-deep chains. The outputs of those chains are called rdy_s and bit_s. Only rdy_s and bit_s are used internally.
- WAIT: data_ack=0.
  - If rdy_s=1: shift bit_s in LSB-side (instruction <= {instruction[INSTR_W-2:0], bit_s}), increment bit_count, go to ACK.
  - Exactly one bit is captured per handshake.
- ACK: data_ack=1 is registered on the WAIT->ACK edge, so data_ack rises SYNC_STAGES+1 cycles after the data_ready pin rises.
  - Hold ACK while rdy_s=1.
  - When rdy_s=0 and bit_count==TOTAL: go to DONE and drive instr_valid=1 on the same edge.
  - When rdy_s=0 and bit_count<TOTAL: go to WAIT.
  - data_ack falls on the leaving edge.
- TOTAL = INSTR_W, or INSTR_W+1 when parity is compiled in.
- DONE: data_ack=0, instr_valid=1, instruction frozen.
  - A new data_ready is not acknowledged while in DONE; this is the backpressure mechanism, and the sender stalls.
  - On an edge with instr_ready=1: instr_valid goes to 0, bit_count goes to 0, go to WAIT.
  - instr_ready=1 while instr_valid=0 is ignored.
- First bit received ends in the instruction MSB. Bits from the previous word are fully shifted out by the end of the frame. instruction keeps its last value until the next frame's first capture.
- Timeout (TIMEOUT_CYC>0):
  - The timer runs in ACK, and in WAIT while bit_count>0.
  - It clears on every state transition and is idle in DONE and in WAIT with bit_count=0.
  - When it reaches TIMEOUT_CYC: frame_err=1 for one cycle, bit_count=0, instruction=0, data_ack=0, go to WAIT.
  - If the sender is still asserting data_ready, that bit is treated as the first bit of a new frame.
- Simultaneous events: a timeout and a valid state transition on the same edge resolve in favour of the transition. In DONE, instr_ready is sampled in the same cycle that instr_valid is observed, giving zero-bubble acceptance.
- parity_err and frame_err never assert together.

Optional Feature:
- Macro: SERIAL_INSTR_PARITY_EN.
- Defined: TOTAL=INSTR_W+1. The final bit is an even-parity bit and is not shifted into instruction.
  - At ACK->DONE, if the XOR of all INSTR_W+1 bits is 1: do not enter DONE. Instead pulse parity_err for 1 cycle, clear bit_count and instruction, go to WAIT.
- Undefined: TOTAL=INSTR_W, no parity logic, parity_err tied 0.

Test Plan:
- Release reset, then send 10'b1011001110 with full handshakes, instr_ready=0 -> 10 data_ack pulses, instruction=10'h2CE, instr_valid=1 and held, state=2.
- With the above word pending, the sender raises data_ready for the next frame -> data_ack stays 0 and instruction holds 10'h2CE. Assert instr_ready for 1 cycle -> instr_valid=0 next cycle, the pending bit is acked and capture resumes.
- Send 4 bits, then hold data_ready=0 for 64 cycles -> single frame_err pulse, bit_count=0. A following frame 10'h155 is received as 10'h155.
- Drive reset=0 after 5 bits while data_ack=1 -> data_ack, instr_valid, bit_count and state go to 0 without a clk edge. After release, a full frame 10'h2CE is received correctly.
- With SERIAL_INSTR_PARITY_EN, send 10'h155 then parity bit 1 -> instr_valid=1, instruction=10'h155. Send 10'h155 then parity bit 0 -> parity_err pulse, instr_valid stays 0.
- Drive instr_ready=1 continuously and send back-to-back frames 10'h001 and 10'h3FF -> each instr_valid lasts exactly 1 cycle with the correct value, and no data_ack is missed.
